// File: rtl/decim_pkg.sv
// ============================================================================
// Module   : decim_pkg
// Brief    : Shared types and constants for the stream decimator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decim_pkg;

    typedef enum logic [0:0] {
        DECIM_PICK = 1'b0,
        DECIM_AVG  = 1'b1
    } decim_mode_e;

    localparam int unsigned DROP_W = 16;

endpackage

`default_nettype wire

// File: rtl/stream_decimator.sv
// ============================================================================
// Module   : stream_decimator
// Brief    : Decimates a signed sample stream by 2**LOG2_R (pick or average)
//            and formats each result with FRAC_W fractional zero bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_decimator
    import decim_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned LOG2_R = 6,
    parameter decim_mode_e MODE   = DECIM_PICK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   x_data_i,
    input  logic              x_valid_i,
    output logic              x_ready_o,
    output logic [OUT_W-1:0]  y_data_o,
    output logic              y_valid_o,
    input  logic              y_ready_i,
    output logic [DROP_W-1:0] drop_count_o
);

    localparam int unsigned R     = 1 << LOG2_R;
    localparam int unsigned ACC_W = IN_W + LOG2_R;
    localparam int unsigned PH_W  = (LOG2_R > 0) ? LOG2_R : 1;

    logic [PH_W-1:0]          phase_q, phase_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]         y_data_q, y_data_d;
    logic                     y_valid_q, y_valid_d;
    logic [DROP_W-1:0]        drop_q, drop_d;

    logic                     w_accept;
    logic                     w_drop;
    logic                     w_last;
    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [IN_W-1:0]   w_avg;
    logic signed [IN_W-1:0]   w_res;
    logic signed [OUT_W-1:0]  w_res_ext;
    logic [OUT_W-1:0]         w_fmt;

    assign x_ready_o    = ~y_valid_q | y_ready_i;
    assign w_accept     = x_valid_i & x_ready_o;
    assign w_drop       = x_valid_i & ~x_ready_o;
    assign w_last       = (phase_q == PH_W'(R - 1));

    // Phase 0 restarts the group, so a stale partial sum never leaks forward.
    assign w_x_ext      = ACC_W'($signed(x_data_i));
    assign w_sum        = (phase_q == '0) ? w_x_ext : (acc_q + w_x_ext);
    assign w_avg        = IN_W'(w_sum >>> LOG2_R);
    assign w_res        = (MODE == DECIM_AVG) ? w_avg : $signed(x_data_i);
    assign w_res_ext    = OUT_W'(w_res);
    assign w_fmt        = w_res_ext << FRAC_W;

    always_comb begin
        phase_d   = phase_q;
        acc_d     = acc_q;
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        drop_d    = drop_q;

        if (w_accept) begin
            phase_d = w_last ? '0 : (phase_q + PH_W'(1));
            acc_d   = w_sum;
        end

        // A new result on the handshake edge keeps y_valid high: no bubble.
        if (w_accept && w_last) begin
            y_valid_d = 1'b1;
            y_data_d  = w_fmt;
        end else if (y_valid_q && y_ready_i) begin
            y_valid_d = 1'b0;
        end

        if (w_drop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q   <= '0;
            acc_q     <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            drop_q    <= drop_d;
        end
    end

    assign y_data_o     = y_data_q;
    assign y_valid_o    = y_valid_q;
    assign drop_count_o = drop_q;

endmodule

`default_nettype wire

// File: doc/stream_decimator.md
STREAM_DECIMATOR -- requirements
Module: stream_decimator

Interface
REQ-001 SHALL have parameter IN_W, default 16, input sample width (signed two's complement).
REQ-002 SHALL have parameter FRAC_W, default 8, zero LSBs appended on output.
REQ-003 SHALL have parameter OUT_W, default 32, output width; legal only when OUT_W >= IN_W+FRAC_W.
REQ-004 SHALL have parameter LOG2_R, default 6, decimation ratio R = 2**LOG2_R, legal range 0..10.
REQ-005 SHALL have parameter MODE, default DECIM_PICK, selecting DECIM_PICK or DECIM_AVG.
REQ-006 SHALL have port clk  input  1  the only clock; every register is on its rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port x  dstream sink  N=IN_W  input samples (data/valid/ready).
REQ-009 SHALL have port y  dstream source  N=OUT_W  decimated, formatted samples (data/valid/ready).
REQ-010 SHALL have port drop_count  output  16  number of x beats presented while x.ready=0.

Function
REQ-011 SHALL accept an input beat only when x.valid && x.ready.
REQ-012 SHALL drive x.ready = ~y.valid | y.ready, from registered y.valid only.
REQ-013 SHALL keep a LOG2_R-bit phase counter that increments on each accepted beat and wraps from R-1 to 0.
REQ-014 SHALL, in DECIM_PICK, take the sample accepted at phase R-1 as the group result.
REQ-015 SHALL, in DECIM_AVG, sum the R accepted samples in a signed accumulator of IN_W+LOG2_R bits (never overflows) and take sum >>> LOG2_R (arithmetic shift, floor) as the group result.
REQ-016 SHALL restart the accumulator with the incoming sample (not add) at phase 0.
REQ-017 SHALL format the result as {sign-extension to OUT_W, result[IN_W-1:0], FRAC_W zeros}.
REQ-018 SHALL load y.data and set y.valid on the clk edge that accepts the phase R-1 beat (one-cycle latency).
REQ-019 SHALL hold y.data and y.valid stable while y.valid && !y.ready.
REQ-020 SHALL clear y.valid after a y handshake unless a new result loads on the same edge, in which case y.valid stays 1 and y.data takes the new result.
REQ-021 SHALL NOT advance the phase or accumulator on dropped beats (x.valid && !x.ready).
REQ-022 SHALL increment drop_count on each dropped beat, saturating at 0xFFFF.
REQ-023 SHALL, when LOG2_R=0, pass every accepted sample through (formatted), in both modes.

Reset
REQ-024 SHALL on reset assertion set phase=0, accumulator=0, y.valid=0, y.data=0, drop_count=0, independent of clk.
REQ-025 SHALL discard any partial group in progress when reset is asserted.
REQ-026 SHALL present x.ready=1 while reset is held and after release.

Structure
REQ-027 SHALL take decim_mode_e (DECIM_PICK, DECIM_AVG) from shared package decim_pkg, which also holds the 16-bit drop-counter width constant.
REQ-028 SHALL be a single module with no sub-modules; the one-deep output register is written inline.

Verification (IN_W=16, FRAC_W=8, OUT_W=32, LOG2_R=2 unless stated)
REQ-029 SHALL check PICK: inputs 1..8 back-to-back, y.ready=1 -> y = 0x00000400, then 0x00000800, each one cycle after the 4th/8th accept.
REQ-030 SHALL check AVG: inputs 10,11,12,13 -> 0x00000B00; inputs -1,-2,-3,-4 -> 0xFFFFFD00 (floor of -2.5).
REQ-031 SHALL check backpressure: y.ready=0 with a result pending, 4 more x beats -> x.ready=0, drop_count=4, y.data unchanged; y.ready=1 -> handshake, x.ready returns to 1.
REQ-032 SHALL check a simultaneous y handshake and phase-3 accept -> y.valid stays 1 and the new value appears on the next cycle with no bubble.
REQ-033 SHALL check reset mid-group: accept 5,6, pulse reset asynchronously, then accept 1,2,3,4 in AVG -> single output 0x00000200, drop_count=0.
REQ-034 SHALL check saturation: force 70000 dropped beats -> drop_count=0xFFFF and held.
